riscv_muldiv_unit: RTL and testbench
====================================

# riscv_muldiv_unit

Iterative RV32M multiply/divide unit attached to the execute stage. It is the multi-cycle successor to the single-cycle ALU path: it accepts one M-extension operation per start pulse and stalls the pipeline while busy. It returns an XLEN-bit result with rd tag and a one-cycle done pulse. Radix (bits retired per cycle) is parametrised to trade area for latency.

## Interface
- XLEN, 32, operand/result width
- BITS_PER_CYCLE, 1, bits retired per iteration; legal 1,2,4,8 and must divide XLEN, else elaboration error
- REG_ADDR_WIDTH, 5, rd tag width
- Clocking and reset: one clock; reset is synchronous and active-low.
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  synchronous active-low reset
- flush  in  1  abort current operation, no done
- start  in  1  launch operation; sampled only when not busy
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  in  XLEN  operand A / dividend
- rs2_data  in  XLEN  operand B / divisor
- rd_addr_in  in  REG_ADDR_WIDTH  destination tag
- busy  out  1  operation in progress
- stall_out  out  1  combinational: start | busy
- done  out  1  one-cycle pulse, result valid
- result  out  XLEN  result, held until next accepted start
- rd_addr_out  out  REG_ADDR_WIDTH  tag of result, held with result

## Operation
- N = XLEN/BITS_PER_CYCLE iterations. States: IDLE, RUN, FIX, DONE.
- IDLE/DONE + start & !flush: latch funct3, rd tag, operand magnitudes and sign flags, and set count=N-1. Go to RUN, or straight to DONE on the fast path.
- RUN: retire BITS_PER_CYCLE bits per cycle. Multiply is shift-add on magnitudes into a 2·XLEN product. Divide is restoring on magnitudes. At count==0, go to FIX; otherwise decrement.
- FIX: apply sign correction and select the output word, then go to DONE.
  - MUL returns product low word.
  - MULH/MULHSU/MULHU return product high word.
  - Product is negated (2·XLEN) when signed operand signs differ. MULHSU treats rs2 as unsigned.
  - DIV quotient is negative when signs differ. REM takes the sign of the dividend.
- DONE: done=1 for exactly one cycle. Next state is IDLE, or RUN if start is present; back-to-back starts are allowed.
- Fast path (start→DONE in one cycle, result loaded directly):
  - divisor==0: DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow (rs1=most-negative, rs2=−1): DIV → rs1; REM → 0.
- start while busy is ignored; no queueing.
- flush in any state → IDLE next cycle; the in-flight op never produces done. flush together with start: flush wins, start is dropped.
- Reset values: state IDLE, busy 0, done 0, result 0, rd_addr_out 0, count 0. Reset mid-operation discards the operation.

## Timing
- start accepted in cycle t. RUN occupies t+1..t+N, FIX is t+N+1, done/result are valid in t+N+2.
  - Default parameters: done at t+34.
  - BITS_PER_CYCLE=4: done at t+10.
- Fast path: done in t+1.
- busy=1 from t+1 through FIX, and 0 in the DONE cycle. stall_out is 1 in cycle t (start) through FIX.
- result/rd_addr_out are registered, update only on the cycle entering DONE, and stay stable otherwise.
- No combinational path from rs1_data/rs2_data to any output.

## Test plan
- MUL with rs1=7, rs2=0xFFFFFFFD (default params), start at t → done at t+34, result=0xFFFFFFEB, rd_addr_out equals the tag. busy high t+1..t+33.
- MULH with 0x80000000 × 0x80000000 → 0x40000000. MULHU with 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU with 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7%2 → 0xFFFFFFFF; DIVU 0xFFFFFFFE/2 → 0x7FFFFFFF.
- Fast path:
  - DIV 5/0 → 0xFFFFFFFF at t+1.
  - REMU 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000.
  - REM of the same → 0.
- flush at t+10 of a DIV → no done; busy=0 at t+11. A new start at t+11 completes normally at t+45. A start asserted at t+5 (while busy) is ignored.
- BITS_PER_CYCLE=4: a back-to-back start in the DONE cycle gives two done pulses 10 cycles apart. reset_n low mid-RUN → all outputs at reset values on the next edge, no done.

Source files
------------

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, retiring BITS_PER_CYCLE bits per cycle, with a final sign-fix cycle.
module riscv_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      start,
  input  logic [2:0]                funct3,
  input  logic [XLEN-1:0]           rs1_data,
  input  logic [XLEN-1:0]           rs2_data,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_in,
  output logic                      busy,
  output logic                      stall_out,
  output logic                      done,
  output logic [XLEN-1:0]           result,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_out
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (!((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) || (BITS_PER_CYCLE == 4) ||
        (BITS_PER_CYCLE == 8)) || ((XLEN % BITS_PER_CYCLE) != 0)) begin : g_bad_radix
    $error("riscv_muldiv_unit: BITS_PER_CYCLE must be 1, 2, 4 or 8 and divide XLEN");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] x,
                                                      input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  state_t                    state, state_nxt;
  logic                      accept;
  logic [CNT_W-1:0]          count;
  logic [2:0]                op_q;
  logic [XLEN-1:0]           opnd_q, acc_hi, acc_lo;
  logic                      neg_q, neg_r;
  logic [REG_ADDR_WIDTH-1:0] rd_q;

  // Operand decode at start: signedness, magnitudes and the divide fast path
  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic                   signed_a, signed_b, a_neg, b_neg;
  logic [XLEN-1:0]        a_mag, b_mag, fast_res;
  logic                   div0, ovf, fast;

  always_comb begin
    rs1_s    = rs1_data;
    rs2_s    = rs2_data;
    signed_a = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    signed_b = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100) ||
               (funct3 == 3'b110);
    a_neg    = signed_a && (rs1_s < 0);
    b_neg    = signed_b && (rs2_s < 0);
    a_mag    = cond_neg(rs1_data, a_neg);
    b_mag    = cond_neg(rs2_data, b_neg);
    div0     = funct3[2] && (rs2_data == '0);
    ovf      = funct3[2] && !funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
               (rs2_data == '1);
    fast     = div0 || ovf;
    if (div0) fast_res = funct3[1] ? rs1_data : '1;
    else      fast_res = funct3[1] ? '0 : rs1_data;
  end

  // Iteration datapath: multiply accumulates into {acc_hi, acc_lo} while shifting the
  // multiplier out of acc_lo; divide shifts dividend bits from acc_lo into acc_hi.
  logic [XLEN-1:0] hi_c, lo_c;
  logic [XLEN:0]   rem_sh, diff, sum;

  always_comb begin
    hi_c   = acc_hi;
    lo_c   = acc_lo;
    rem_sh = '0;
    diff   = '0;
    sum    = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q[2]) begin
        rem_sh = {hi_c, lo_c[XLEN-1]};
        diff   = rem_sh - {1'b0, opnd_q};
        lo_c   = {lo_c[XLEN-2:0], ~diff[XLEN]};
        hi_c   = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
      end else begin
        sum  = {1'b0, hi_c} + (lo_c[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        lo_c = {sum[0], lo_c[XLEN-1:1]};
        hi_c = sum[XLEN:1];
      end
    end
  end

  // Sign correction and output word select
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod_s = cond_neg_wide({acc_hi, acc_lo}, neg_q);
    unique case (op_q)
      3'b000:                 fix_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = cond_neg(acc_lo, neg_q);
      default:                fix_res = cond_neg(acc_hi, neg_r);
    endcase
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start && !flush) begin
          accept    = 1'b1;
          state_nxt = fast ? S_DONE : S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (count == '0) state_nxt = S_FIX;
      end
      default: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
    endcase
    if (flush) state_nxt = S_IDLE;
    stall_out = start || busy;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      count       <= '0;
      result      <= '0;
      rd_addr_out <= '0;
    end else begin
      state <= state_nxt;
      if (accept)                         count <= CNT_W'(N - 1);
      else if (state == S_RUN && count != '0) count <= count - 1'b1;
      if (accept && fast) begin
        result      <= fast_res;
        rd_addr_out <= rd_addr_in;
      end else if (state == S_FIX && !flush) begin
        result      <= fix_res;
        rd_addr_out <= rd_q;
      end
    end
  end

  // Operand/accumulator registers carry no reset; they are only read under valid state
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= funct3;
      rd_q   <= rd_addr_in;
      opnd_q <= funct3[2] ? b_mag : a_mag;
      acc_hi <= '0;
      acc_lo <= funct3[2] ? a_mag : b_mag;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
    end else if (state == S_RUN) begin
      acc_hi <= hi_c;
      acc_lo <= lo_c;
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed bench for riscv_muldiv_unit: default radix-1 instance plus a radix-4 instance.
module tb_riscv_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, flush0, start0, busy0, stall0, done0;
  logic [2:0]  f3_0;
  logic [31:0] a0, b0, res0;
  logic [4:0]  tag0, rd0;

  logic        rst1_n, flush1, start1, busy1, stall1, done1;
  logic [2:0]  f3_1;
  logic [31:0] a1, b1, res1;
  logic [4:0]  tag1, rd1;

  riscv_muldiv_unit u0 (
    .clk(clk), .reset_n(rst0_n), .flush(flush0), .start(start0), .funct3(f3_0),
    .rs1_data(a0), .rs2_data(b0), .rd_addr_in(tag0), .busy(busy0), .stall_out(stall0),
    .done(done0), .result(res0), .rd_addr_out(rd0)
  );

  riscv_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .REG_ADDR_WIDTH(5)) u1 (
    .clk(clk), .reset_n(rst1_n), .flush(flush1), .start(start1), .funct3(f3_1),
    .rs1_data(a1), .rs2_data(b1), .rd_addr_in(tag1), .busy(busy1), .stall_out(stall1),
    .done(done1), .result(res1), .rd_addr_out(rd1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Launch one op on u0 at the current cycle and track it to its done pulse.
  // intr_at > 0 drives an illegal-while-busy fast-path start at that cycle offset.
  task automatic run_op0(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input int lat, input logic [31:0] exp,
                         input string name, input int intr_at);
    int got;
    bit busy_ok;
    start0 = 1'b1; f3_0 = f3; a0 = a; b0 = b; tag0 = tag;
    #1 chk({name, " stall"}, {31'b0, stall0}, 32'd1);
    got = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 60 && got < 0; k++) begin
      tick();
      if (done0) got = k;
      else if (!busy0) busy_ok = 1'b0;
      start0 = (k == intr_at);
      if (k == intr_at) begin
        f3_0 = 3'b100; a0 = 32'd9; b0 = 32'd0; tag0 = 5'd31;
      end
    end
    start0 = 1'b0;
    chk({name, " latency"}, got, lat);
    chk({name, " result"}, res0, exp);
    chk({name, " rd"}, {27'b0, rd0}, {27'b0, tag});
    chk({name, " busy in done"}, {31'b0, busy0}, 32'd0);
    chk({name, " busy while running"}, {31'b0, busy_ok}, 32'd1);
    tick();
    chk({name, " done pulse width"}, {31'b0, done0}, 32'd0);
  endtask

  initial begin
    int t1, t2;
    logic [31:0] ra, rb;
    logic [4:0]  da, db;
    bit nodone;

    rst0_n = 0; flush0 = 0; start0 = 0; f3_0 = 0; a0 = 0; b0 = 0; tag0 = 0;
    rst1_n = 0; flush1 = 0; start1 = 0; f3_1 = 0; a1 = 0; b1 = 0; tag1 = 0;
    repeat (3) tick();
    chk("reset busy", {31'b0, busy0}, 32'd0);
    chk("reset done", {31'b0, done0}, 32'd0);
    chk("reset stall", {31'b0, stall0}, 32'd0);
    chk("reset result", res0, 32'd0);
    chk("reset rd", {27'b0, rd0}, 32'd0);
    chk("reset u1 result", res1, 32'd0);
    rst0_n = 1; rst1_n = 1;
    tick();

    run_op0(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 34, 32'hFFFF_FFEB, "MUL", 0);
    run_op0(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 34, 32'h4000_0000, "MULH", 0);
    run_op0(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 34, 32'hFFFF_FFFE, "MULHU", 0);
    run_op0(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 34, 32'hFFFF_FFFF, "MULHSU", 0);
    run_op0(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 34, 32'hFFFF_FFFD, "DIV", 0);
    run_op0(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 34, 32'hFFFF_FFFF, "REM", 0);
    run_op0(3'b101, 32'hFFFF_FFFE, 32'd2, 5'd12, 34, 32'h7FFF_FFFF, "DIVU", 0);
    run_op0(3'b100, 32'd5, 32'd0, 5'd13, 1, 32'hFFFF_FFFF, "DIV by zero", 0);
    run_op0(3'b111, 32'd5, 32'd0, 5'd14, 1, 32'd5, "REMU by zero", 0);
    run_op0(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1, 32'h8000_0000, "DIV ovf", 0);
    run_op0(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1, 32'd0, "REM ovf", 0);

    // Flush at t+10 of a DIV, with an ignored start at t+5
    start0 = 1; f3_0 = 3'b100; a0 = 32'd100; b0 = 32'd7; tag0 = 5'd3;
    nodone = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (done0) nodone = 1'b0;
      start0 = (k == 5);
      if (k == 5) begin f3_0 = 3'b100; a0 = 32'd9; b0 = 32'd0; tag0 = 5'd30; end
      flush0 = (k == 10);
    end
    tick();
    if (done0) nodone = 1'b0;
    flush0 = 0;
    chk("flush no done", {31'b0, nodone}, 32'd1);
    chk("flush busy cleared", {31'b0, busy0}, 32'd0);
    chk("flush result held", res0, 32'd0);
    chk("flush rd held", {27'b0, rd0}, 32'd16);
    run_op0(3'b100, 32'd100, 32'd7, 5'd9, 34, 32'd14, "DIV after flush", 5);

    // Radix-4 back-to-back: second start issued in the first DONE cycle
    start1 = 1; f3_1 = 3'b000; a1 = 32'd3; b1 = 32'd4; tag1 = 5'd1;
    t1 = -1; t2 = -1; ra = '0; rb = '0; da = '0; db = '0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      start1 = 0;
      if (done1 && t1 < 0) begin
        t1 = k; ra = res1; da = rd1;
        start1 = 1; f3_1 = 3'b101; a1 = 32'd100; b1 = 32'd10; tag1 = 5'd2;
      end else if (done1 && t2 < 0) begin
        t2 = k; rb = res1; db = rd1;
      end
    end
    chk("r4 first done", t1, 32'd10);
    chk("r4 second done", t2, 32'd20);
    chk("r4 first result", ra, 32'd12);
    chk("r4 first rd", {27'b0, da}, 32'd1);
    chk("r4 second result", rb, 32'd10);
    chk("r4 second rd", {27'b0, db}, 32'd2);

    // Radix-4 reset mid-RUN
    start1 = 1; f3_1 = 3'b000; a1 = 32'd5; b1 = 32'd6; tag1 = 5'd7;
    for (int k = 1; k <= 4; k++) begin
      tick();
      start1 = 0;
    end
    rst1_n = 0;
    tick();
    chk("mid reset busy", {31'b0, busy1}, 32'd0);
    chk("mid reset done", {31'b0, done1}, 32'd0);
    chk("mid reset stall", {31'b0, stall1}, 32'd0);
    chk("mid reset result", res1, 32'd0);
    chk("mid reset rd", {27'b0, rd1}, 32'd0);
    rst1_n = 1;
    nodone = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done1) nodone = 1'b0;
    end
    chk("mid reset no done", {31'b0, nodone}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
